// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage load/store initiator: size codes,
// FSM states, byte-enable patterns and small decode helpers.
package mem_access_unit_pkg;

    // Access size codes; 2'b11 is decoded as a word everywhere.
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // Byte-enable patterns the data memory honours besides one-hot bytes.
    localparam logic [3:0] BE_W  = 4'b1111;
    localparam logic [3:0] BE_LO = 4'b0011;
    localparam logic [3:0] BE_HI = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SPLIT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // One-hot byte enable for a lane offset.
    function automatic logic [3:0] be_onehot(input logic [1:0] off);
        return 4'b0001 << off;
    endfunction

    // True when the access can be done with a single legal byte-enable pattern.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
        if (size == SZ_B) return 1'b1;
        if (size == SZ_H) return (off[0] == 1'b0);
        return (off == 2'b00);
    endfunction

    // Index of the last byte of a split access (byte accesses never split).
    function automatic logic [1:0] last_k(input logic [1:0] size);
        return (size == SZ_H) ? 2'd1 : 2'd3;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline request/response and data-memory port of the MEM-stage unit.
// The slave modport is the unit; the master modport is its environment.
interface mem_access_unit_if #(
    parameter int ADDR_W = 12
);
    logic              req_valid;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              stall;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic [ADDR_W-3:0] dm_A;
    logic              dm_memWrite;
    logic [3:0]        dm_be;
    logic [31:0]       dm_D;
    logic [31:0]       dm_Dout;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, dm_Dout,
        output stall, resp_valid, resp_rdata, dm_A, dm_memWrite, dm_be, dm_D
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, dm_Dout,
        input  stall, resp_valid, resp_rdata, dm_A, dm_memWrite, dm_be, dm_D
    );
endinterface

// File: rtl/mem_access_unit_load_extend.sv
// Load lane select plus sign/zero extension. Used both on raw memory read
// data (aligned path) and on the byte-assembly register (split path).
module load_extend
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] result
);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Pick the addressed byte/half lane and extend it to 32 bits.
    always_comb begin
        // NOTE: every combinational output gets a value on every path, so no latch is inferred.
        lane_b = data[{offset, 3'b000} +: 8];
        lane_h = offset[1] ? data[31:16] : data[15:0];
        result = data;
        case (size)
            SZ_B:    result = {{24{sign_ext & lane_b[7]}}, lane_b};
            SZ_H:    result = {{16{sign_ext & lane_h[15]}}, lane_h};
            default: result = data;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator. Aligned accesses go straight to the data
// memory in the request cycle; misaligned halves/words are broken into
// single-byte accesses while the pipeline is stalled.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_access_unit_if.slave   bus
);
    state_t            state;
    logic [1:0]        k;
    logic [31:0]       asm_q;
    logic              lat_write;
    logic              lat_signed;
    logic [1:0]        lat_size;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_wdata;

    logic [ADDR_W-1:0] req_a;
    logic              req_aligned;
    logic [ADDR_W-1:0] split_a;
    logic [7:0]        split_rbyte;
    logic [7:0]        split_wbyte;
    logic [31:0]       ext_direct;
    logic [31:0]       ext_asm;
    logic              unused_addr_bits;

    assign req_a            = bus.req_addr[ADDR_W-1:0];
    assign req_aligned      = is_aligned(bus.req_size, req_a[1:0]);
    assign split_a          = lat_addr + ADDR_W'(k);
    assign split_rbyte      = bus.dm_Dout[{split_a[1:0], 3'b000} +: 8];
    assign split_wbyte      = lat_wdata[{k, 3'b000} +: 8];
    assign unused_addr_bits = ^bus.req_addr[31:ADDR_W];

    load_extend u_ext_direct (
        .data     (bus.dm_Dout),
        .offset   (req_a[1:0]),
        .size     (bus.req_size),
        .sign_ext (bus.req_signed),
        .result   (ext_direct)
    );

    load_extend u_ext_asm (
        .data     (asm_q),
        .offset   (2'b00),
        .size     (lat_size),
        .sign_ext (lat_signed),
        .result   (ext_asm)
    );

    // Control state, split byte index, request latch and load assembly.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (!rst_n) begin
            // NOTE: the request latch is pure datapath, loaded before use, so it is left out of reset.
            state <= ST_IDLE;
            k     <= 2'd0;
            asm_q <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid && !req_aligned) begin
                        lat_write  <= bus.req_write;
                        lat_signed <= bus.req_signed;
                        lat_size   <= bus.req_size;
                        lat_addr   <= req_a;
                        lat_wdata  <= bus.req_wdata;
                        k          <= 2'd0;
                        asm_q      <= 32'd0;
                        state      <= ST_SPLIT;
                    end
                end
                ST_SPLIT: begin
                    if (!lat_write) begin
                        asm_q[{k, 3'b000} +: 8] <= split_rbyte;
                    end
                    if (k == last_k(lat_size)) begin
                        state <= ST_DONE;
                    end else begin
                        k <= k + 2'd1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Memory port and pipeline handshake; everything is held at zero in reset.
    always_comb begin
        bus.stall       = 1'b0;
        bus.resp_valid  = 1'b0;
        bus.resp_rdata  = 32'd0;
        bus.dm_A        = '0;
        bus.dm_memWrite = 1'b0;
        bus.dm_be       = 4'b0000;
        bus.dm_D        = 32'd0;
        if (rst_n) begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        if (req_aligned) begin
                            bus.dm_A        = req_a[ADDR_W-1:2];
                            bus.dm_memWrite = bus.req_write;
                            bus.resp_valid  = 1'b1;
                            bus.resp_rdata  = bus.req_write ? 32'd0 : ext_direct;
                            case (bus.req_size)
                                SZ_B: begin
                                    bus.dm_be = be_onehot(req_a[1:0]);
                                    bus.dm_D  = bus.req_write ? {24'd0, bus.req_wdata[7:0]} : 32'd0;
                                end
                                SZ_H: begin
                                    bus.dm_be = req_a[1] ? BE_HI : BE_LO;
                                    bus.dm_D  = bus.req_write ? {16'd0, bus.req_wdata[15:0]} : 32'd0;
                                end
                                default: begin
                                    bus.dm_be = BE_W;
                                    bus.dm_D  = bus.req_write ? bus.req_wdata : 32'd0;
                                end
                            endcase
                        end else begin
                            bus.stall = 1'b1;
                        end
                    end
                end
                ST_SPLIT: begin
                    bus.stall       = 1'b1;
                    bus.dm_A        = split_a[ADDR_W-1:2];
                    bus.dm_be       = be_onehot(split_a[1:0]);
                    bus.dm_memWrite = lat_write;
                    bus.dm_D        = lat_write ? {24'd0, split_wbyte} : 32'd0;
                end
                ST_DONE: begin
                    bus.resp_valid = 1'b1;
                    bus.resp_rdata = lat_write ? 32'd0 : ext_asm;
                end
                default: ;
            endcase
        end
    end
endmodule
